// File: rtl/i2s_tx_if.sv
// Parallel sample side of the I2S transmitter: stereo sample handoff plus frame status.
// The master supplies samples with a one-cycle valid; the slave reports frame loads and underrun.
// No backpressure: a valid sample always overwrites the holding registers.
interface i2s_tx_if;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        frame_strobe;
  logic        underrun;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  frame_strobe,
    input  underrun
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output frame_strobe,
    output underrun
  );
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: 16-bit stereo, BCLK = clk/(2*CLK_DIV), 32 BCLK per frame.
// Latency: a captured sample goes out starting at the next frame load (at most one frame + 2*CLK_DIV clk).
// No backpressure: samples are accepted every cycle; a frame with no fresh sample sets sticky underrun.
module i2s_tx #(
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          SIGNED_IN = 1'b0
) (
  input  logic           clk_i,
  input  logic           resetn_i,
  i2s_tx_if.slave        smp,
  output logic           i2s_bclk_o,
  output logic           i2s_lrck_o,
  output logic           i2s_dout_o
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Offset-binary inputs become two's complement by flipping the MSB.
  function automatic logic [15:0] conv(input logic [15:0] x);
    logic [15:0] y;
    y = x;
    if (!SIGNED_IN) begin
      y[15] = ~x[15];
    end
    return y;
  endfunction

  logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
  logic             bclk_q,     bclk_d;
  logic [4:0]       bit_cnt_q,  bit_cnt_d;
  logic             lrck_q,     lrck_d;
  logic             dout_q,     dout_d;
  logic [31:0]      sr_q,       sr_d;
  logic [15:0]      hold_l_q,   hold_l_d;
  logic [15:0]      hold_r_q,   hold_r_d;
  logic             fresh_q,    fresh_d;
  logic             strobe_q,   strobe_d;
  logic             underrun_q, underrun_d;

  logic tick;
  logic fall;
  logic load;

  // Divider: wrap at CLK_DIV-1 and toggle BCLK; a 1->0 toggle is the serial update event.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    fall      = tick & bclk_q;
    load      = fall & (bit_cnt_q == 5'd0);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = bclk_q ^ tick;
  end

  // Serializer: load both channels when bit_cnt leaves 0, otherwise shift MSB-first.
  // Loading at 0->1 gives the one-BCLK I2S delay: R[0] of a frame lands on bit_cnt 0 of the next.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    sr_d      = sr_q;
    dout_d    = dout_q;
    strobe_d  = 1'b0;
    if (fall) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      lrck_d    = bit_cnt_d[4];
      if (load) begin
        sr_d     = {conv(hold_l_q), conv(hold_r_q)};
        dout_d   = sr_d[31];
        strobe_d = 1'b1;
      end else begin
        sr_d   = {sr_q[30:0], 1'b0};
        dout_d = sr_q[30];
      end
    end
  end

  // Holding registers: a new sample wins over a same-cycle load, which still takes the old contents.
  always_comb begin
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    fresh_d    = fresh_q;
    underrun_d = underrun_q;
    if (load) begin
      fresh_d = 1'b0;
      if (!fresh_q) begin
        underrun_d = 1'b1;
      end
    end
    if (smp.sample_valid) begin
      hold_l_d = smp.sample_l;
      hold_r_d = smp.sample_r;
      fresh_d  = 1'b1;
    end
  end

  // State registers; reset abandons any partial frame.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= 5'd0;
      lrck_q     <= 1'b0;
      dout_q     <= 1'b0;
      sr_q       <= 32'd0;
      hold_l_q   <= 16'd0;
      hold_r_q   <= 16'd0;
      fresh_q    <= 1'b0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      dout_q     <= dout_d;
      sr_q       <= sr_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      fresh_q    <= fresh_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign i2s_bclk_o       = bclk_q;
  assign i2s_lrck_o       = lrck_q;
  assign i2s_dout_o       = dout_q;
  assign smp.frame_strobe = strobe_q;
  assign smp.underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: three instances cover CLK_DIV=2 signed, CLK_DIV=2 offset-binary, CLK_DIV=1.
// Each test task drives one instance and checks frame timing, serial bits, LRCK and underrun.
// Outputs are sampled 1 time unit after the rising edge.
module tb_i2s_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic bclk_a, lrck_a, dout_a;
  logic bclk_b, lrck_b, dout_b;
  logic bclk_c, lrck_c, dout_c;

  i2s_tx_if ifa();
  i2s_tx_if ifb();
  i2s_tx_if ifc();

  i2s_tx #(.CLK_DIV(2), .SIGNED_IN(1'b1)) u_a (
    .clk_i(clk), .resetn_i(resetn), .smp(ifa),
    .i2s_bclk_o(bclk_a), .i2s_lrck_o(lrck_a), .i2s_dout_o(dout_a));
  i2s_tx #(.CLK_DIV(2), .SIGNED_IN(1'b0)) u_b (
    .clk_i(clk), .resetn_i(resetn), .smp(ifb),
    .i2s_bclk_o(bclk_b), .i2s_lrck_o(lrck_b), .i2s_dout_o(dout_b));
  i2s_tx #(.CLK_DIV(1), .SIGNED_IN(1'b1)) u_c (
    .clk_i(clk), .resetn_i(resetn), .smp(ifc),
    .i2s_bclk_o(bclk_c), .i2s_lrck_o(lrck_c), .i2s_dout_o(dout_c));

  int   sel;
  logic cur_bclk, cur_lrck, cur_dout, cur_fs, cur_ur;

  always_comb begin
    case (sel)
      0: {cur_bclk, cur_lrck, cur_dout, cur_fs, cur_ur} =
           {bclk_a, lrck_a, dout_a, ifa.frame_strobe, ifa.underrun};
      1: {cur_bclk, cur_lrck, cur_dout, cur_fs, cur_ur} =
           {bclk_b, lrck_b, dout_b, ifb.frame_strobe, ifb.underrun};
      default: {cur_bclk, cur_lrck, cur_dout, cur_fs, cur_ur} =
           {bclk_c, lrck_c, dout_c, ifc.frame_strobe, ifc.underrun};
    endcase
  end

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic prev_bclk = 1'b0;

  task automatic tick();
    prev_bclk = cur_bclk;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_valid(input int which, input logic [15:0] l, input logic [15:0] r,
                             input logic v);
    case (which)
      0: begin ifa.sample_l = l; ifa.sample_r = r; ifa.sample_valid = v; end
      1: begin ifb.sample_l = l; ifb.sample_r = r; ifb.sample_valid = v; end
      default: begin ifc.sample_l = l; ifc.sample_r = r; ifc.sample_valid = v; end
    endcase
  endtask

  task automatic pulse_valid(input int which, input logic [15:0] l, input logic [15:0] r);
    drive_valid(which, l, r, 1'b1);
    tick();
    drive_valid(which, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (prev_bclk && !cur_bclk) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (cur_fs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Starting in a frame_strobe cycle, gather 32 bits (bit_cnt 1..31 then 0 of the next frame).
  task automatic collect(output logic [31:0] d, output logic [31:0] lr, output int per);
    bit ok;
    int c0;
    d   = {31'd0, cur_dout};
    lr  = {31'd0, cur_lrck};
    per = 0;
    for (int k = 1; k < 32; k++) begin
      c0 = cyc;
      wait_fall(ok);
      if (!ok) begin
        n_chk++; n_fail++;
        $display("FAIL collect_timeout: no BCLK fall within 64 clk at bit %0d (sel %0d)", k, sel);
        return;
      end
      if (k == 1) per = cyc - c0;
      d  = {d[30:0], cur_dout};
      lr = {lr[30:0], cur_lrck};
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) tick();
    n_chk++;
    if ({bclk_a, lrck_a, dout_a, ifa.frame_strobe, ifa.underrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %b want 00000",
               {bclk_a, lrck_a, dout_a, ifa.frame_strobe, ifa.underrun});
    end
    n_chk++;
    if ({bclk_b, lrck_b, dout_b, ifb.frame_strobe, ifb.underrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %b want 00000",
               {bclk_b, lrck_b, dout_b, ifb.frame_strobe, ifb.underrun});
    end
    n_chk++;
    if ({bclk_c, lrck_c, dout_c, ifc.frame_strobe, ifc.underrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_c: got %b want 00000",
               {bclk_c, lrck_c, dout_c, ifc.frame_strobe, ifc.underrun});
    end
  endtask

  // Measures first BCLK rise and first frame_strobe cycle after reset release.
  task automatic startup_timing(output int rise, output int fs_c);
    rise = 0;
    fs_c = 0;
    for (int i = 0; i < 40 && fs_c == 0; i++) begin
      if (cur_bclk && rise == 0) rise = cyc;
      if (cur_fs) fs_c = cyc;
      else tick();
    end
  endtask

  task automatic test_basic();
    logic [31:0] d, lr;
    int per, rise, fs_c;
    sel = 0;
    do_reset();
    pulse_valid(0, 16'hA5F0, 16'h0F0F);
    startup_timing(rise, fs_c);
    n_chk++;
    if (rise !== 2) begin n_fail++; $display("FAIL basic_rise: got cycle %0d want 2", rise); end
    n_chk++;
    if (fs_c !== 4) begin n_fail++; $display("FAIL basic_fs: got cycle %0d want 4", fs_c); end
    collect(d, lr, per);
    n_chk++;
    if (d !== 32'hA5F00F0F) begin n_fail++; $display("FAIL basic_data: got %h want a5f00f0f", d); end
    n_chk++;
    if (lr !== 32'h0001FFFE) begin n_fail++; $display("FAIL basic_lrck: got %h want 0001fffe", lr); end
    n_chk++;
    if (per !== 4) begin n_fail++; $display("FAIL basic_bclk_period: got %0d want 4", per); end
    n_chk++;
    if (cur_ur !== 1'b0) begin n_fail++; $display("FAIL basic_underrun: got %b want 0", cur_ur); end
  endtask

  task automatic test_conv();
    logic [31:0] d, lr;
    int per;
    bit ok;
    sel = 1;
    do_reset();
    pulse_valid(1, 16'h0000, 16'h0000);
    wait_fs(ok);
    collect(d, lr, per);
    n_chk++;
    if (!ok || d !== 32'h80008000) begin
      n_fail++; $display("FAIL conv_zero: got %h (fs %0d) want 80008000", d, ok);
    end
    pulse_valid(1, 16'hFFFF, 16'hFFFF);
    wait_fs(ok);
    collect(d, lr, per);
    n_chk++;
    if (!ok || d !== 32'h7FFF7FFF) begin
      n_fail++; $display("FAIL conv_ones: got %h (fs %0d) want 7fff7fff", d, ok);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] d, lr;
    int per;
    bit ok;
    sel = 0;
    do_reset();
    tick();
    n_chk++;
    if (cur_ur !== 1'b0) begin n_fail++; $display("FAIL ur_pre: got %b want 0", cur_ur); end
    wait_fs(ok);
    n_chk++;
    if (!ok || cyc !== 4) begin n_fail++; $display("FAIL ur_fs_cycle: got %0d want 4", cyc); end
    n_chk++;
    if (cur_ur !== 1'b1) begin n_fail++; $display("FAIL ur_set: got %b want 1", cur_ur); end
    collect(d, lr, per);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ur_zero_data: got %h want 00000000", d); end
    pulse_valid(0, 16'h1111, 16'h2222);
    wait_fs(ok);
    collect(d, lr, per);
    n_chk++;
    if (!ok || d !== 32'h11112222) begin
      n_fail++; $display("FAIL ur_next_data: got %h want 11112222", d);
    end
    n_chk++;
    if (cur_ur !== 1'b1) begin n_fail++; $display("FAIL ur_sticky: got %b want 1", cur_ur); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, lr;
    int per;
    bit ok;
    sel = 0;
    do_reset();
    pulse_valid(0, 16'h0000, 16'h0000);
    while (cyc < 20) tick();
    pulse_valid(0, 16'hABCD, 16'hABCD);
    while (cyc < 131) tick();
    pulse_valid(0, 16'h1234, 16'h5678);
    n_chk++;
    if (cur_fs !== 1'b1 || cyc !== 132) begin
      n_fail++; $display("FAIL b2b_fs: got fs %b at cycle %0d want 1 at 132", cur_fs, cyc);
    end
    collect(d, lr, per);
    n_chk++;
    if (d !== 32'hABCDABCD) begin n_fail++; $display("FAIL b2b_old: got %h want abcdabcd", d); end
    wait_fs(ok);
    n_chk++;
    if (!ok || cyc !== 260) begin n_fail++; $display("FAIL b2b_period: got %0d want 260", cyc); end
    collect(d, lr, per);
    n_chk++;
    if (d !== 32'h12345678) begin n_fail++; $display("FAIL b2b_new: got %h want 12345678", d); end
    n_chk++;
    if (cur_ur !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun: got %b want 0", cur_ur); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int rise, fs_c;
    sel = 0;
    do_reset();
    wait_fs(ok);
    pulse_valid(0, 16'hFFFF, 16'hFFFF);
    wait_fs(ok);
    for (int i = 0; i < 19; i++) wait_fall(ok);
    n_chk++;
    if ({cur_lrck, cur_dout, cur_ur} !== 3'b111) begin
      n_fail++; $display("FAIL mid_prereset: got lrck/dout/ur %b want 111", {cur_lrck, cur_dout, cur_ur});
    end
    resetn = 1'b0;
    tick();
    n_chk++;
    if ({cur_bclk, cur_lrck, cur_dout, cur_fs, cur_ur} !== 5'b0) begin
      n_fail++; $display("FAIL mid_reset: got %b want 00000", {cur_bclk, cur_lrck, cur_dout, cur_fs, cur_ur});
    end
    resetn = 1'b1;
    cyc = 0;
    tick();
    startup_timing(rise, fs_c);
    n_chk++;
    if (rise !== 2 || fs_c !== 4) begin
      n_fail++; $display("FAIL mid_restart: got rise %0d fs %0d want 2 4", rise, fs_c);
    end
    n_chk++;
    if (cur_ur !== 1'b1) begin n_fail++; $display("FAIL mid_underrun: got %b want 1", cur_ur); end
  endtask

  task automatic test_div1();
    bit ok;
    int c0, hi, fsn;
    sel = 2;
    do_reset();
    wait_fs(ok);
    n_chk++;
    if (!ok || cyc !== 2) begin n_fail++; $display("FAIL div1_first_fs: got %0d want 2", cyc); end
    c0 = cyc;
    wait_fs(ok);
    n_chk++;
    if (!ok || cyc - c0 !== 64) begin n_fail++; $display("FAIL div1_period: got %0d want 64", cyc - c0); end
    hi = 0;
    fsn = 0;
    for (int i = 0; i < 64; i++) begin
      hi  += int'(cur_lrck);
      fsn += int'(cur_fs);
      tick();
    end
    n_chk++;
    if (hi !== 32) begin n_fail++; $display("FAIL div1_lrck_duty: got %0d high want 32", hi); end
    n_chk++;
    if (fsn !== 1) begin n_fail++; $display("FAIL div1_fs_count: got %0d want 1", fsn); end
  endtask

  initial begin
    sel = 0;
    resetn = 1'b0;
    drive_valid(0, 16'h0000, 16'h0000, 1'b0);
    drive_valid(1, 16'h0000, 16'h0000, 1'b0);
    drive_valid(2, 16'h0000, 16'h0000, 1'b0);
    test_reset();
    test_basic();
    test_conv();
    test_underrun();
    test_back_to_back();
    test_reset_midframe();
    test_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
